mul_div_sequencer: RTL and testbench
====================================

Name: mul_div_sequencer

Overview:
- Multi-cycle controller that sequences the signed 32-bit multiply and divide operations of the Mini-SRC datapath and writes the HI/LO result registers.
- Sits beside the combinational ALU. The control unit issues a start pulse with an opcode and operands, stalls on busy, and reads HI/LO when done pulses.
- Multiply uses iterative radix-2 Booth. Divide uses restoring division on operand magnitudes, followed by sign correction.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- OP_MUL, 5'b10000, opcode that selects multiply.
- OP_DIV, 5'b01111, opcode that selects divide.

Ports:
- clock  in  1  rising-edge clock
- clear_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- opcode  in  5  operation select; sampled with start
- A  in  WIDTH  multiplicand / dividend; sampled with start
- B  in  WIDTH  multiplier / divisor; sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- HI  out  WIDTH  mul: upper product; div: remainder
- LO  out  WIDTH  mul: lower product; div: quotient

Behaviour:
- Reset (asynchronous, clear_n=0): state=IDLE, iteration counter=0, busy=0, done=0, HI=0, LO=0, all internal operand and accumulator registers=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, opcode=OP_MUL at edge E0:
  - capture A and B; clear the accumulator; Booth Q(-1)=0; counter=WIDTH; go to MUL.
- IDLE, start=1, opcode=OP_DIV, B!=0:
  - capture |A| and |B| plus both sign bits; clear the remainder; counter=WIDTH; go to DIV.
- IDLE, start=1, opcode=OP_DIV, B==0:
  - go directly to DONE at E0.
  - LO=32'hFFFFFFFF, HI=A.
- IDLE, start=1, any other opcode: ignored; stay in IDLE; HI/LO unchanged; no done.
- start while busy (MUL, DIV or DONE): ignored. No queuing. Operands in flight are unaffected.
- MUL: one Booth step per edge.
  - Bit pair {Q0,Q(-1)}: 01 adds M to acc, 10 subtracts M from acc, 00/11 no add.
  - Then arithmetic right shift of {acc,Q,Q(-1)}; counter decrements.
  - At the edge where the counter reaches 0 (E32): HI=acc, LO=Q; go to DONE.
- DIV: one restoring step per edge.
  - Shift {R,Q} left by 1; trial subtract R-|B|.
  - If the trial is non-negative, keep it and set Q0=1; otherwise restore R and set Q0=0.
- DIV, final edge (E32) writes sign-corrected results:
  - LO = quotient, negated if sign(A)^sign(B). Truncation toward zero.
  - HI = remainder, negated if sign(A). Remainder sign follows the dividend.
- Arithmetic wraps modulo 2^WIDTH. 0x80000000/-1 yields LO=0x80000000, HI=0; no overflow flag.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
  - busy=1 in DONE, so a start in the DONE cycle is ignored.
- Latency: mul and div with B!=0 take 33 cycles from the start-sample edge to done high. Div-by-zero takes 1 cycle.
- HI/LO change only at a completion edge or on reset. They hold their value through IDLE and through the next operation until that operation completes.
- Reset mid-operation: abort immediately to the reset state. No done is produced and partial results are discarded.

Optional Feature:
- Macro MUL_DIV_SEQ_DIV_ZERO_FLAG_EN.
- Defined: adds output port div_zero (1 bit, reset 0). div_zero pulses high in the same cycle as done, only for a div-by-zero completion.
- Undefined: port absent. All other behaviour, including div-by-zero results and latency, is identical.

Decomposition:
- Shared package mini_src_pkg holds the 5-bit opcode localparams (OP_MUL, OP_DIV and the existing ALU codes) and the state enum typedef for the sequencer.
- One combinational sub-module is natural: div_restore_step. It takes R, Q and divisor, and returns the next R and Q. The Booth step stays inline.

Test Plan:
- Mul 7 × -3 (A=0x00000007, B=0xFFFFFFFD) -> done exactly 33 cycles after the start edge; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for 33 cycles.
- Mul 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0x00000000.
- Div -7 / 2 (A=0xFFFFFFF9, B=0x00000002) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 cycles.
- Div 5 / 0 -> done one cycle after the start edge; LO=0xFFFFFFFF, HI=0x00000005; div_zero=1 with the macro, port absent without it.
- Mul 3×4 started, then start with Div 100/7 at cycle 10 -> second request ignored; HI=0, LO=12; no second done.
- Mul in progress, clear_n pulsed low at cycle 15 -> busy=0, HI=LO=0 immediately; no done. A subsequent Div 100/7 -> LO=14, HI=2.

Source files
------------

// File: rtl/mini_src_pkg.sv
// rtl/mini_src_pkg.sv - Mini-SRC opcode constants and sequencer state type
package mini_src_pkg;

  // ALU / datapath opcodes (5-bit instruction field)
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one restoring-division step on unsigned magnitudes
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] r_wide;

  // Shift {R,Q} left, trial-subtract the divisor, keep it only if it did not go negative
  always_comb begin
    r_wide = {r_in, q_in[WIDTH-1]};
    if (r_wide >= {1'b0, divisor}) begin
      // the difference is below the divisor, so it fits in WIDTH bits
      r_out = r_wide[WIDTH-1:0] - divisor;
      q_out = {q_in[WIDTH-2:0], 1'b1};
    end else begin
      r_out = r_wide[WIDTH-1:0];
      q_out = {q_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// rtl/mul_div_sequencer.sv - multi-cycle signed mul/div sequencer for HI/LO (option: MUL_DIV_SEQ_DIV_ZERO_FLAG_EN)
module mul_div_sequencer
  import mini_src_pkg::*;
#(
  parameter int         WIDTH  = 32,
  parameter logic [4:0] OP_MUL = mini_src_pkg::OP_MUL,
  parameter logic [4:0] OP_DIV = mini_src_pkg::OP_DIV
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
`ifdef MUL_DIV_SEQ_DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  seq_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;      // one guard bit so M = -2^(W-1) subtracts without overflow
  logic [WIDTH-1:0] m;        // multiplicand, or divisor magnitude
  logic [WIDTH-1:0] q;        // Booth multiplier, or dividend/quotient
  logic             q_m1;
  logic [WIDTH-1:0] rem;
  logic             sign_a, sign_b;

  logic             last;
  logic [WIDTH:0]   m_ext, booth_sum, acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] r_nx, q_nx;

  assign last  = (cnt == CNT_W'(1));
  assign a_mag = A[WIDTH-1] ? -A : A;
  assign b_mag = B[WIDTH-1] ? -B : B;

  div_restore_step #(.WIDTH(WIDTH)) u_div_step (
    .r_in    (rem),
    .q_in    (q),
    .divisor (m),
    .r_out   (r_nx),
    .q_out   (q_nx)
  );

  // State register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state and status outputs
  always_comb begin
    next_state = state;
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL)      next_state = ST_MUL;
          else if (opcode == OP_DIV) next_state = (B == '0) ? ST_DONE : ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (last) next_state = ST_DONE;
      ST_DONE:        next_state = ST_IDLE;
      default:        next_state = ST_IDLE;
    endcase
  end

  // Booth add/subtract of M on bit pair {Q0,Q-1}, then arithmetic right shift
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    acc_sh = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    q_sh   = {booth_sum[0], q[WIDTH-1:1]};
  end

  // Operand capture, iteration and HI/LO write at completion
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt    <= '0;
      acc    <= '0;
      m      <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      rem    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && opcode == OP_MUL) begin
            acc  <= '0;
            m    <= A;
            q    <= B;
            q_m1 <= 1'b0;
            cnt  <= CNT_W'(WIDTH);
          end else if (start && opcode == OP_DIV) begin
            if (B == '0) begin
              HI <= A;
              LO <= '1;
            end else begin
              rem    <= '0;
              m      <= b_mag;
              q      <= a_mag;
              sign_a <= A[WIDTH-1];
              sign_b <= B[WIDTH-1];
              cnt    <= CNT_W'(WIDTH);
            end
          end
        end
        ST_MUL: begin
          acc  <= acc_sh;
          q    <= q_sh;
          q_m1 <= q[0];
          cnt  <= cnt - 1'b1;
          if (last) begin
            HI <= acc_sh[WIDTH-1:0];
            LO <= q_sh;
          end
        end
        ST_DIV: begin
          rem <= r_nx;
          q   <= q_nx;
          cnt <= cnt - 1'b1;
          if (last) begin
            // quotient truncates toward zero; remainder takes the dividend's sign
            LO <= (sign_a ^ sign_b) ? -q_nx : q_nx;
            HI <= sign_a ? -r_nx : r_nx;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MUL_DIV_SEQ_DIV_ZERO_FLAG_EN
  logic dz_q;

  // Remember that the pending completion is a divide-by-zero
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      dz_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      dz_q <= start && (opcode == OP_DIV) && (B == '0);
    end else if (state == ST_DONE) begin
      dz_q <= 1'b0;
    end
  end

  assign div_zero = done && dz_q;
`else
  // no flag port; a divide-by-zero is visible only through HI/LO
`endif

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb/tb_mul_div_sequencer.sv - self-checking bench for mul_div_sequencer
module tb_mul_div_sequencer;
  import mini_src_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         clear_n;
  logic         start;
  logic [4:0]   opcode;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] HI, LO;
`ifdef MUL_DIV_SEQ_DIV_ZERO_FLAG_EN
  logic         div_zero;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clock = ~clock;

  mul_div_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .start    (start),
    .opcode   (opcode),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .HI       (HI),
    .LO       (LO)
`ifdef MUL_DIV_SEQ_DIV_ZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic straight from the operation definitions
  task automatic model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output bit dz);
    logic signed [63:0] p;
    logic [W-1:0] ua, ub, uq, ur;
    dz = 1'b0;
    if (op == OP_MUL) begin
      p  = $signed(a) * $signed(b);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else begin
      ua = a[W-1] ? -a : a;
      ub = b[W-1] ? -b : b;
      uq = ua / ub;
      ur = ua % ub;
      lo = (a[W-1] ^ b[W-1]) ? -uq : uq;
      hi = a[W-1] ? -ur : ur;
    end
  endtask

  // Issue one request; optionally inject a second start at cycle inject_at or reset at reset_at
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inject_at, input int reset_at);
    logic [W-1:0] mh, ml;
    bit mdz;
    int lat = 0, busy_n = 0, extra = 0, exp_lat;
    bit aborted = 0;
    model(op, a, b, mh, ml, mdz);
    exp_lat = (op == OP_DIV && b == 0) ? 1 : 33;
    @(negedge clock);
    start = 1'b1; opcode = op; A = a; B = b;
    @(negedge clock);
    start = 1'b0; opcode = 5'($urandom); A = $urandom; B = $urandom;
    for (int n = 1; n <= 40; n++) begin
      if (n == reset_at) begin
        clear_n = 1'b0;
        #1;
        chk({tag, " rst busy"}, 64'(busy), 64'(0));
        chk({tag, " rst HI"}, 64'(HI), 64'(0));
        chk({tag, " rst LO"}, 64'(LO), 64'(0));
        exp_hi = '0; exp_lo = '0;
        aborted = 1;
        @(negedge clock);
        clear_n = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (n == 16) begin
        chk({tag, " hold HI"}, 64'(HI), 64'(exp_hi));
        chk({tag, " hold LO"}, 64'(LO), 64'(exp_lo));
      end
      start = (n == inject_at);
      if (n == inject_at) begin opcode = OP_DIV; A = 100; B = 7; end
      if (done) begin
        lat = n;
        exp_hi = mh; exp_lo = ml;
        chk({tag, " HI"}, 64'(HI), 64'(mh));
        chk({tag, " LO"}, 64'(LO), 64'(ml));
`ifdef MUL_DIV_SEQ_DIV_ZERO_FLAG_EN
        chk({tag, " div_zero"}, 64'(div_zero), 64'(mdz));
`endif
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    start = 1'b0;
    if (!aborted) begin
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " busy cycles"}, 64'(busy_n), 64'(exp_lat));
      chk({tag, " idle after done"}, 64'({busy, done}), 64'(0));
    end
    for (int n = 0; n < 40; n++) begin
      if (done) extra++;
      @(negedge clock);
    end
    chk({tag, " no extra done"}, 64'(extra), 64'(0));
    chk({tag, " final HI"}, 64'(HI), 64'(exp_hi));
    chk({tag, " final LO"}, 64'(LO), 64'(exp_lo));
  endtask

  // A start with a non-mul/div opcode must leave everything untouched
  task automatic run_ignored(input string tag, input logic [4:0] op);
    @(negedge clock);
    start = 1'b1; opcode = op; A = $urandom; B = $urandom;
    @(negedge clock);
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk({tag, " busy/done"}, 64'({busy, done}), 64'(0));
      @(negedge clock);
    end
    chk({tag, " HI"}, 64'(HI), 64'(exp_hi));
    chk({tag, " LO"}, 64'(LO), 64'(exp_lo));
  endtask

  initial begin
    logic [4:0]   rop;
    logic [W-1:0] ra, rb;
    clear_n = 1'b0; start = 1'b0; opcode = '0; A = '0; B = '0;
    @(negedge clock);
    @(negedge clock);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset HI", 64'(HI), 64'(0));
    chk("reset LO", 64'(LO), 64'(0));
    clear_n = 1'b1;

    run_op("mul 7x-3", OP_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 0, 0);
    run_op("mul min*min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
    run_op("div 5/0", OP_DIV, 32'h0000_0005, 32'h0000_0000, 0, 0);
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div 7/-2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0);
    run_ignored("ign add", OP_ADD);
    run_ignored("ign rol", OP_ROL);
    run_op("mul 3x4 busy start", OP_MUL, 32'd3, 32'd4, 10, 0);
    run_op("mul start in done", OP_MUL, 32'd9, 32'hFFFF_FFF0, 33, 0);
    run_op("mul reset", OP_MUL, 32'h1234_5678, 32'h0BAD_CAFE, 0, 15);
    run_op("div 100/7", OP_DIV, 32'd100, 32'd7, 0, 0);

    for (int i = 0; i < 16; i++) begin
      rop = ($urandom_range(0, 1) == 1) ? OP_MUL : OP_DIV;
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 100));
        2:       rb = -32'($urandom_range(1, 100));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rop, ra, rb, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
